seq_mul: RTL and testbench



---
 rtl/mul_pkg.sv | 20 ++
 rtl/seq_mul.sv | 106 ++++++++++
 tb/tb_seq_mul.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and constants for the iterative multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    localparam int MUL_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage : mul_pkg

`default_nettype wire

// File: rtl/seq_mul.sv
// ============================================================================
// Module      : seq_mul
// Description : Iterative shift-add unsigned multiplier, start/ready handshake.
//               Optional macro SEQ_MUL_EARLY_EXIT_EN ends RUN once the
//               remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mul_start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           mul_rdy,
    output logic           busy,
    output logic [2*W-1:0] p
);

    localparam int               c_cnt_w = $clog2(W);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(W - 1);

    mul_state_t         r_state;
    logic [2*W-1:0]     r_mcand;
    logic [W-1:0]       r_mplier;
    logic [2*W-1:0]     r_acc;
    logic [c_cnt_w-1:0] r_count;

    logic [2*W-1:0]     w_sum;
    logic [W-1:0]       w_mplier_next;
    logic               w_zero_skip;
    logic               w_last;

    assign w_sum         = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mplier_next = r_mplier >> 1;

`ifdef SEQ_MUL_EARLY_EXIT_EN
    // Zero skip applies only from IDLE so that a back-to-back start in DONE
    // never produces two adjacent ready pulses.
    assign w_zero_skip = (b == '0);
    assign w_last      = (r_count == c_last) || (w_mplier_next == '0);
`else
    assign w_zero_skip = 1'b0;
    assign w_last      = (r_count == c_last);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            p        <= '0;
            mul_rdy  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    mul_rdy <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                    if (mul_start) begin
                        r_mcand  <= {{W{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_count  <= '0;
                        if (w_zero_skip && (r_state == IDLE)) begin
                            r_state <= DONE;
                            p       <= '0;
                            mul_rdy <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            busy    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_count  <= r_count + 1'b1;
                    if (w_last) begin
                        r_state <= DONE;
                        p       <= w_sum;
                        mul_rdy <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    mul_rdy <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : seq_mul

`default_nettype wire

// File: tb/tb_seq_mul.sv
// ============================================================================
// Module      : tb_seq_mul
// Description : Self-checking bench for seq_mul (vector table, corner
//               sequences and randomized operands against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mul;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mul_start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           mul_rdy;
    logic           busy;
    logic [2*W-1:0] p;

    int checks = 0;
    int errors = 0;

    seq_mul #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mul_start (mul_start),
        .a         (a),
        .b         (b),
        .mul_rdy   (mul_rdy),
        .busy      (busy),
        .p         (p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Cycles from the accepting edge until mul_rdy is seen (accept cycle counts as 1).
    function automatic int exp_lat(input logic [W-1:0] bv, input bit from_done);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        if (bv == '0) return from_done ? 2 : 1;
        for (int i = W - 1; i >= 0; i--)
            if (bv[i]) return i + 2;
        return 1;
`else
        return (from_done || !from_done) ? W + 1 : W + 1;
`endif
    endfunction

    // Called just after a negedge with the DUT idle.
    task automatic run_mul(input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic [2*W-1:0] ep, input string nm);
        int cyc;
        int bcnt;
        int lat;
        lat = exp_lat(ib, 1'b0);
        mul_start = 1'b1;
        a = ia;
        b = ib;
        @(negedge clk);
        mul_start = 1'b0;
        cyc  = 1;
        bcnt = 0;
        while (!mul_rdy && cyc < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, cyc, lat);
        check({nm, " busy cycles"}, bcnt, lat - 1);
        check({nm, " product"}, p, ep);
        @(negedge clk);
        check({nm, " rdy single"}, mul_rdy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int rdy_cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2*W-1:0] rp;

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd77,  8'd0,   16'd0};
        vecs[3] = '{8'd1,   8'd1,   16'd1};
        vecs[4] = '{8'd128, 8'd2,   16'd256};
        vecs[5] = '{8'd200, 8'd3,   16'd600};
        vecs[6] = '{8'd0,   8'd128, 16'd0};
        vecs[7] = '{8'd17,  8'd15,  16'd255};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset p", p, 0);
        check("reset rdy", mul_rdy, 0);
        check("reset busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        // Product holds through idle cycles
        run_mul(8'd255, 8'd255, 16'd65025, "max");
        repeat (3) begin
            @(negedge clk);
            check("idle hold p", p, 65025);
        end

        // Start held high: second start accepted in DONE
        mul_start = 1'b1;
        a = 8'd3;
        b = 8'd5;
        @(negedge clk);
        cyc = 1;
        while (!mul_rdy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b first latency", cyc, exp_lat(8'd5, 1'b0));
        check("b2b first p", p, 15);
        a = 8'd7;
        b = 8'd9;
        @(negedge clk);
        cyc = 1;
        check("b2b no double rdy", mul_rdy, 0);
        check("b2b second busy", busy, 1);
        check("b2b old p readable", p, 15);
        while (!mul_rdy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b second latency", cyc, exp_lat(8'd9, 1'b1));
        check("b2b second p", p, 63);
        mul_start = 1'b0;
        @(negedge clk);
        check("b2b idle after", busy, 0);

        // Start pulsed mid-RUN is ignored
        mul_start = 1'b1;
        a = 8'd13;
        b = 8'd11;
        @(negedge clk);
        mul_start = 1'b0;
        cyc = 1;
        repeat (2) begin
            @(negedge clk);
            cyc++;
        end
        mul_start = 1'b1;
        a = 8'd99;
        b = 8'd99;
        @(negedge clk);
        mul_start = 1'b0;
        cyc++;
        check("midrun old p", p, 63);
        while (!mul_rdy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("midrun latency", cyc, exp_lat(8'd11, 1'b0));
        check("midrun p", p, 143);
        @(negedge clk);

        // Reset four cycles into RUN
        mul_start = 1'b1;
        a = 8'd13;
        b = 8'd11;
        @(negedge clk);
        mul_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst pre busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst p", p, 0);
        check("rst rdy", mul_rdy, 0);
        rst = 1'b0;
        rdy_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (mul_rdy) rdy_cnt++;
        end
        check("rst no rdy", rdy_cnt, 0);

`ifdef SEQ_MUL_EARLY_EXIT_EN
        run_mul(8'd200, 8'd1, 16'd200, "early b1");
        run_mul(8'd45, 8'd0, 16'd0, "early b0");
`endif

        // Randomized operands against plain arithmetic
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
            rp = (2*W)'(ra) * (2*W)'(rb);
            run_mul(ra, rb, rp, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_mul

`default_nettype wire
